// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage.
// Holds the datapath widths, the B-operand select and state encodings,
// the ALUOp codes used by the downstream ALU, and the small helpers that
// decide which source registers an instruction actually reads.
package ex_operand_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 5;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    BSEL_RT    = 2'd0,
    BSEL_IMM   = 2'd1,
    BSEL_SHAMT = 2'd2,
    BSEL_RS    = 2'd3
  } bsel_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_LDWAIT = 2'd2
  } state_e;

  localparam logic [ALUOP_W-1:0] ALUOP_NOP = 5'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = 5'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_AND = 5'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = 5'd5;
  localparam logic [ALUOP_W-1:0] ALUOP_SLL = 5'd8;
  localparam logic [ALUOP_W-1:0] ALUOP_SRL = 5'd9;
  localparam logic [ALUOP_W-1:0] ALUOP_SRA = 5'd10;

  // rs feeds A unless A is switched to rt, and feeds B for variable shifts.
  function automatic logic rs_is_used(input logic asel, input bsel_e bsel);
    return (!asel) || (bsel == BSEL_RS);
  endfunction

  // rt feeds A for shifts, B for R-type, and is the store data when no rd is written.
  function automatic logic rt_is_used(input logic asel, input bsel_e bsel, input logic regwrite);
    return asel || (bsel == BSEL_RT) || (!regwrite);
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding select for one source operand.
// Ports:
//   src_addr_i / src_data_i      latched register index and value
//   exm_* / mwb_*                EX/MEM and MEM/WB writeback info
//   fwd_data_o                   resolved operand value
//   load_hit_o                   EX/MEM holds a load targeting this source
module ex_operand_stage_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int RAW = REG_AW
) (
  input  logic [RAW-1:0] src_addr_i,
  input  logic [DW-1:0]  src_data_i,
  input  logic           exm_regwrite_i,
  input  logic           exm_memread_i,
  input  logic [RAW-1:0] exm_rd_i,
  input  logic [DW-1:0]  exm_result_i,
  input  logic           mwb_regwrite_i,
  input  logic [RAW-1:0] mwb_rd_i,
  input  logic [DW-1:0]  mwb_data_i,
  output logic [DW-1:0]  fwd_data_o,
  output logic           load_hit_o
);

  logic src_nz;

  always_comb begin
    src_nz     = |src_addr_i;
    fwd_data_o = src_data_i;
    // $0 always reads as zero; a load result in EX/MEM is not ready yet.
    if (!src_nz) begin
      fwd_data_o = '0;
    end else if (exm_regwrite_i && !exm_memread_i && (exm_rd_i == src_addr_i)) begin
      fwd_data_o = exm_result_i;
    end else if (mwb_regwrite_i && (mwb_rd_i == src_addr_i)) begin
      fwd_data_o = mwb_data_i;
    end
    load_hit_o = src_nz && exm_memread_i && (exm_rd_i == src_addr_i);
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select.
// Accepts decoded instructions over a valid/ready handshake, forwards from
// EX/MEM and MEM/WB, stalls on load-use, and presents A/B/ALUOp plus the
// destination/store info to the MEM stage.
// Ports: clk_i/rstn_i, in_valid_i/in_ready_o (decode side), id_* decoded
// fields, flush_i, out_ready_i/out_valid_o (EX/MEM side), exm_*/mwb_*
// forwarding sources, alu_a_o/alu_b_o/alu_op_o, ex_* MEM info, lu_stall_o.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  ST_EMPTY  | no instruction held
//  ST_FULL   | instruction held, operands resolvable
//  ST_LDWAIT | held behind a load in EX/MEM
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int RAW = REG_AW,
  parameter int OPW = ALUOP_W
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [RAW-1:0]     id_rs_addr_i,
  input  logic [RAW-1:0]     id_rt_addr_i,
  input  logic [DW-1:0]      id_rs_data_i,
  input  logic [DW-1:0]      id_rt_data_i,
  input  logic [DW-1:0]      id_imm_i,
  input  logic [SHAMT_W-1:0] id_shamt_i,
  input  logic               id_asel_i,
  input  logic [1:0]         id_bsel_i,
  input  logic [OPW-1:0]     id_aluop_i,
  input  logic [RAW-1:0]     id_rd_addr_i,
  input  logic               id_regwrite_i,
  input  logic               id_memread_i,
  input  logic               flush_i,
  input  logic               out_ready_i,
  input  logic               exm_regwrite_i,
  input  logic               exm_memread_i,
  input  logic [RAW-1:0]     exm_rd_i,
  input  logic [DW-1:0]      exm_result_i,
  input  logic               mwb_regwrite_i,
  input  logic [RAW-1:0]     mwb_rd_i,
  input  logic [DW-1:0]      mwb_data_i,
  output logic               out_valid_o,
  output logic [DW-1:0]      alu_a_o,
  output logic [DW-1:0]      alu_b_o,
  output logic [OPW-1:0]     alu_op_o,
  output logic [DW-1:0]      ex_rt_data_o,
  output logic [RAW-1:0]     ex_rd_addr_o,
  output logic               ex_regwrite_o,
  output logic               ex_memread_o,
  output logic               lu_stall_o
);

  state_e               state_q, state_d;
  logic [RAW-1:0]       rs_addr_q, rt_addr_q, rd_addr_q;
  logic [DW-1:0]        rs_data_q, rt_data_q, imm_q;
  logic [SHAMT_W-1:0]   shamt_q;
  logic                 asel_q, regwrite_q, memread_q;
  bsel_e                bsel_q;
  logic [OPW-1:0]       aluop_q;

  logic [DW-1:0]        rs_fwd, rt_fwd;
  logic                 rs_hit, rt_hit;
  logic                 held, accept, fire, hold;

  ex_operand_stage_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_rs (
    .src_addr_i     (rs_addr_q),
    .src_data_i     (rs_data_q),
    .exm_regwrite_i (exm_regwrite_i),
    .exm_memread_i  (exm_memread_i),
    .exm_rd_i       (exm_rd_i),
    .exm_result_i   (exm_result_i),
    .mwb_regwrite_i (mwb_regwrite_i),
    .mwb_rd_i       (mwb_rd_i),
    .mwb_data_i     (mwb_data_i),
    .fwd_data_o     (rs_fwd),
    .load_hit_o     (rs_hit)
  );

  ex_operand_stage_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd_rt (
    .src_addr_i     (rt_addr_q),
    .src_data_i     (rt_data_q),
    .exm_regwrite_i (exm_regwrite_i),
    .exm_memread_i  (exm_memread_i),
    .exm_rd_i       (exm_rd_i),
    .exm_result_i   (exm_result_i),
    .mwb_regwrite_i (mwb_regwrite_i),
    .mwb_rd_i       (mwb_rd_i),
    .mwb_data_i     (mwb_data_i),
    .fwd_data_o     (rt_fwd),
    .load_hit_o     (rt_hit)
  );

  always_comb begin
    held        = (state_q != ST_EMPTY);
    lu_stall_o  = held && ((rs_is_used(asel_q, bsel_q) && rs_hit) ||
                           (rt_is_used(asel_q, bsel_q, regwrite_q) && rt_hit));
    out_valid_o = held && !lu_stall_o;
    fire        = out_valid_o && out_ready_i;
    // rstn_i term keeps decode from seeing ready while reset is asserted.
    in_ready_o  = rstn_i && (!held || fire);
    accept      = in_valid_i && in_ready_o;
    hold        = held && !fire;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL, ST_LDWAIT: begin
        if (lu_stall_o)           state_d = ST_LDWAIT;
        else if (fire && !accept) state_d = ST_EMPTY;
        else                      state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_EMPTY;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_addr_q  <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      shamt_q    <= '0;
      asel_q     <= 1'b0;
      bsel_q     <= BSEL_RT;
      aluop_q    <= ALUOP_NOP;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        // The squashed instruction must not write anything downstream.
        regwrite_q <= 1'b0;
        memread_q  <= 1'b0;
      end else if (accept) begin
        rs_addr_q  <= id_rs_addr_i;
        rt_addr_q  <= id_rt_addr_i;
        rd_addr_q  <= id_rd_addr_i;
        rs_data_q  <= id_rs_data_i;
        rt_data_q  <= id_rt_data_i;
        imm_q      <= id_imm_i;
        shamt_q    <= id_shamt_i;
        asel_q     <= id_asel_i;
        bsel_q     <= bsel_e'(id_bsel_i);
        aluop_q    <= id_aluop_i;
        regwrite_q <= id_regwrite_i;
        memread_q  <= id_memread_i;
      end else if (hold) begin
        // Capture forwarded values so a result retiring from MEM/WB while we wait is kept.
        rs_data_q <= rs_fwd;
        rt_data_q <= rt_fwd;
      end
    end
  end

  always_comb begin
    alu_a_o = asel_q ? rt_fwd : rs_fwd;
    case (bsel_q)
      BSEL_RT:    alu_b_o = rt_fwd;
      BSEL_IMM:   alu_b_o = imm_q;
      BSEL_SHAMT: alu_b_o = {{(DW-SHAMT_W){1'b0}}, shamt_q};
      BSEL_RS:    alu_b_o = rs_fwd;
      default:    alu_b_o = rt_fwd;
    endcase
  end

  assign alu_op_o      = aluop_q;
  assign ex_rt_data_o  = rt_fwd;
  assign ex_rd_addr_o  = rd_addr_q;
  assign ex_regwrite_o = regwrite_q;
  assign ex_memread_o  = memread_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready;
  logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_aluop, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_asel, id_regwrite, id_memread;
  logic [1:0]  id_bsel;
  logic        flush, out_ready;
  logic        exm_regwrite, exm_memread, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_data;
  logic        out_valid, ex_regwrite, ex_memread, lu_stall;
  logic [31:0] alu_a, alu_b, ex_rt_data;
  logic [4:0]  alu_op, ex_rd_addr;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .id_rs_addr_i(id_rs_addr), .id_rt_addr_i(id_rt_addr),
    .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
    .id_shamt_i(id_shamt), .id_asel_i(id_asel), .id_bsel_i(id_bsel),
    .id_aluop_i(id_aluop), .id_rd_addr_i(id_rd_addr),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
    .flush_i(flush), .out_ready_i(out_ready),
    .exm_regwrite_i(exm_regwrite), .exm_memread_i(exm_memread),
    .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .mwb_regwrite_i(mwb_regwrite), .mwb_rd_i(mwb_rd), .mwb_data_i(mwb_data),
    .out_valid_o(out_valid), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .ex_rt_data_o(ex_rt_data), .ex_rd_addr_o(ex_rd_addr),
    .ex_regwrite_o(ex_regwrite), .ex_memread_o(ex_memread), .lu_stall_o(lu_stall)
  );

  typedef struct {
    logic [4:0]  rs, rt, sh, op, rd;
    logic [31:0] rsd, rtd, imm;
    logic        as, rw, mr;
    logic [1:0]  bs;
  } instr_t;

  typedef struct {
    logic [31:0] a, b, rt;
    logic [4:0]  op, rd;
    logic        rw, mr;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b", nm, act, req);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] rs, input logic [31:0] rsd,
                                input logic [4:0] rt, input logic [31:0] rtd,
                                input logic [31:0] imm, input logic [4:0] sh,
                                input logic as, input logic [1:0] bs, input logic [4:0] op,
                                input logic [4:0] rd, input logic rw, input logic mr);
    instr_t i;
    i.rs = rs; i.rsd = rsd; i.rt = rt; i.rtd = rtd; i.imm = imm; i.sh = sh;
    i.as = as; i.bs = bs; i.op = op; i.rd = rd; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                            input logic [31:0] rt, input logic [4:0] rd, input logic rw,
                            input logic mr);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rt = rt; e.rd = rd; e.rw = rw; e.mr = mr;
    sb.push_back(e);
  endtask

  task automatic drive(input instr_t i);
    id_rs_addr = i.rs; id_rs_data = i.rsd; id_rt_addr = i.rt; id_rt_data = i.rtd;
    id_imm = i.imm; id_shamt = i.sh; id_asel = i.as; id_bsel = i.bs;
    id_aluop = i.op; id_rd_addr = i.rd; id_regwrite = i.rw; id_memread = i.mr;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input instr_t i);
    bit ok;
    ok = 0;
    drive(i);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: actual=in_ready low required=accept within 20 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_fwd();
    exm_regwrite = 0; exm_memread = 0; exm_rd = 0; exm_result = 0;
    mwb_regwrite = 0; mwb_rd = 0; mwb_data = 0;
  endtask

  // Monitor: every transfer on the output side is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: actual alu_a=%h rd=%0d required=no transfer",
                   alu_a, ex_rd_addr);
        end else begin
          e = sb.pop_front();
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
          chk("alu_op", 32'(alu_op), 32'(e.op));
          chk("ex_rt_data", ex_rt_data, e.rt);
          chk("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
          chk1("ex_regwrite", ex_regwrite, e.rw);
          chk1("ex_memread", ex_memread, e.mr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 0; in_valid = 0; flush = 0; out_ready = 1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clear_fwd();
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk1("rst_regwrite", ex_regwrite, 1'b0);
    chk1("rst_lu_stall", lu_stall, 1'b0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    chk1("empty_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // addi r2,r1,5
    expect_out(32'h10, 32'h5, 5'd2, 32'h99, 5'd2, 1, 0);
    send(mk(1, 32'h10, 2, 32'h99, 32'h5, 0, 0, 2'd1, 5'd2, 2, 1, 0));
    @(negedge clk);
    chk1("addi_latency_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // EX/MEM wins over MEM/WB for the same source
    exm_regwrite = 1; exm_rd = 3; exm_result = 32'hDEADBEEF;
    mwb_regwrite = 1; mwb_rd = 3; mwb_data = 32'h1;
    expect_out(32'hDEADBEEF, 32'h10, 5'd2, 32'h66, 5'd5, 1, 0);
    send(mk(3, 32'h1234, 6, 32'h66, 32'h10, 0, 0, 2'd1, 5'd2, 5, 1, 0));
    @(negedge clk);
    @(posedge clk); #1;

    // $0 is never forwarded even when EX/MEM/MEM/WB target it
    exm_rd = 0; mwb_rd = 0;
    expect_out(32'h0, 32'h7, 5'd2, 32'h66, 5'd5, 1, 0);
    send(mk(0, 32'h0, 6, 32'h66, 32'h7, 0, 0, 2'd1, 5'd2, 5, 1, 0));
    @(negedge clk);
    @(posedge clk); #1;
    clear_fwd();

    // MEM/WB forward into rt (B operand and store data)
    mwb_regwrite = 1; mwb_rd = 7; mwb_data = 32'h700;
    expect_out(32'h10, 32'h700, 5'd3, 32'h700, 5'd8, 1, 0);
    send(mk(1, 32'h10, 7, 32'h1, 32'h0, 0, 0, 2'd0, 5'd3, 8, 1, 0));
    @(negedge clk);
    @(posedge clk); #1;
    clear_fwd();

    // back-to-back: sll (A=rt, B=shamt), sllv (A=rt, B=rs), store (rd write off)
    expect_out(32'h80, 32'h3, 5'd8, 32'h80, 5'd9, 1, 0);
    send(mk(0, 32'h0, 8, 32'h80, 32'h0, 5'd3, 1, 2'd2, 5'd8, 9, 1, 0));
    expect_out(32'h80, 32'h4, 5'd8, 32'h80, 5'd10, 1, 0);
    send(mk(9, 32'h4, 8, 32'h80, 32'h0, 5'd0, 1, 2'd3, 5'd8, 10, 1, 0));
    expect_out(32'h100, 32'h4, 5'd2, 32'h2222, 5'd0, 0, 0);
    send(mk(1, 32'h100, 2, 32'h2222, 32'h4, 0, 0, 2'd1, 5'd2, 0, 0, 0));
    @(negedge clk);
    chk1("throughput_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // load in EX/MEM targets rt, but addi does not read rt: no stall
    exm_regwrite = 1; exm_memread = 1; exm_rd = 4; exm_result = 32'hBAD;
    expect_out(32'h10, 32'h9, 5'd2, 32'h11, 5'd4, 1, 0);
    send(mk(1, 32'h10, 4, 32'h11, 32'h9, 0, 0, 2'd1, 5'd2, 4, 1, 0));
    @(negedge clk);
    chk1("nohaz_lu_stall", lu_stall, 1'b0);
    chk1("nohaz_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // load-use on rt with B=rt
    expect_out(32'h10, 32'h55, 5'd2, 32'h55, 5'd6, 1, 0);
    send(mk(1, 32'h10, 4, 32'h11, 32'h0, 0, 0, 2'd0, 5'd2, 6, 1, 0));
    @(negedge clk);
    chk1("lu_stall_on", lu_stall, 1'b1);
    chk1("lu_out_valid", out_valid, 1'b0);
    chk1("lu_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    clear_fwd();
    mwb_regwrite = 1; mwb_rd = 4; mwb_data = 32'h55;
    @(negedge clk);
    chk1("lu_released_valid", out_valid, 1'b1);
    chk1("lu_released_stall", lu_stall, 1'b0);
    @(posedge clk); #1;
    clear_fwd();

    // hold refresh: rs value retires from MEM/WB during the first held cycle only
    out_ready = 0;
    send(mk(10, 32'h1, 0, 32'h0, 32'h2, 0, 0, 2'd1, 5'd2, 11, 1, 0));
    mwb_regwrite = 1; mwb_rd = 10; mwb_data = 32'h77;
    @(negedge clk);
    chk("hold_c1_alu_a", alu_a, 32'h77);
    @(posedge clk); #1;
    clear_fwd();
    @(negedge clk);
    chk("hold_c2_alu_a", alu_a, 32'h77);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_c3_alu_a", alu_a, 32'h77);
    chk1("hold_c3_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    expect_out(32'h77, 32'h2, 5'd2, 32'h0, 5'd11, 1, 0);
    out_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;

    // flush of a held instruction with a new instruction offered
    out_ready = 0;
    send(mk(1, 32'h5, 2, 32'h6, 32'h1, 0, 0, 2'd1, 5'd2, 12, 1, 0));
    flush = 1;
    drive(mk(1, 32'hF0, 2, 32'h0, 32'h1, 0, 0, 2'd1, 5'd2, 13, 1, 0));
    in_valid = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk1("flush_out_valid", out_valid, 1'b0);
    chk1("flush_regwrite", ex_regwrite, 1'b0);
    chk1("flush_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // flush in EMPTY with in_valid: accept is dropped
    out_ready = 1;
    flush = 1; in_valid = 1;
    @(negedge clk);
    chk1("flush_empty_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("flush_drop_valid", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // recovery after flush
    expect_out(32'h21, 32'h3, 5'd4, 32'h0, 5'd14, 1, 0);
    send(mk(1, 32'h21, 0, 32'h0, 32'h3, 0, 0, 2'd1, 5'd4, 14, 1, 0));
    @(negedge clk);
    @(posedge clk); #1;

    // asynchronous reset while an instruction is held
    out_ready = 0;
    send(mk(1, 32'hAA, 2, 32'hBB, 32'h1, 0, 0, 2'd1, 5'd2, 15, 1, 0));
    @(negedge clk);
    chk1("pre_rst_valid", out_valid, 1'b1);
    #2 rstn = 0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_alu_a", alu_a, 32'h0);
    chk("mid_rst_alu_b", alu_b, 32'h0);
    chk1("mid_rst_regwrite", ex_regwrite, 1'b0);
    @(posedge clk); #1;
    rstn = 1; out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("post_rst_valid", out_valid, 1'b0);
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
